// File: rtl/color_freq_meter.sv
// Colour-sensor frequency meter: sweeps the S2/S3 filter selects over up to four
// channels and counts synchronised sensor rising edges over a fixed gate window.
module color_freq_meter #(
  parameter int unsigned GATE_CYCLES   = 1000,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned NUM_CH        = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sensor,
  output logic             s2,
  output logic             s3,
  output logic [CNT_W-1:0] count,
  output logic [1:0]       count_ch,
  output logic             count_valid,
  output logic             overflow,
  output logic             frame_done,
  output logic             busy
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_GATE    = 2'd2;
  localparam logic [1:0] ST_PUBLISH = 2'd3;

  localparam int unsigned TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [1:0]       LAST_CH     = 2'(NUM_CH - 1);

  logic [1:0]       state, state_d;
  logic [TMR_W-1:0] timer, timer_d;
  logic [1:0]       ch, ch_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             sticky, sticky_d;
  logic             sync1, sync2, sync3;
  logic             edge_c;

  logic             s2_d, s3_d, count_valid_d, overflow_d, frame_done_d, busy_d;
  logic [CNT_W-1:0] count_d;
  logic [1:0]       count_ch_d;

  // Two-flop synchroniser plus previous-value register for rising-edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= sensor;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign edge_c = sync2 & ~sync3;

  // State, counters and all outputs are registered here
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      timer       <= '0;
      ch          <= '0;
      cnt         <= '0;
      sticky      <= 1'b0;
      s2          <= 1'b0;
      s3          <= 1'b0;
      count       <= '0;
      count_ch    <= '0;
      count_valid <= 1'b0;
      overflow    <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      timer       <= timer_d;
      ch          <= ch_d;
      cnt         <= cnt_d;
      sticky      <= sticky_d;
      s2          <= s2_d;
      s3          <= s3_d;
      count       <= count_d;
      count_ch    <= count_ch_d;
      count_valid <= count_valid_d;
      overflow    <= overflow_d;
      frame_done  <= frame_done_d;
      busy        <= busy_d;
    end
  end

  // Next-state and next-output logic; the strobe is raised on the edge entering PUBLISH
  always_comb begin
    state_d       = state;
    timer_d       = timer;
    ch_d          = ch;
    cnt_d         = cnt;
    sticky_d      = sticky;
    count_d       = count;
    count_ch_d    = count_ch;
    overflow_d    = overflow;
    count_valid_d = 1'b0;
    frame_done_d  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_SETTLE;
          timer_d = '0;
          ch_d    = '0;
        end
      end
      ST_SETTLE: begin
        if (timer == SETTLE_LAST) begin
          state_d  = ST_GATE;
          timer_d  = '0;
          cnt_d    = '0;
          sticky_d = 1'b0;
        end else begin
          timer_d = timer + TMR_W'(1);
        end
      end
      ST_GATE: begin
        if (edge_c) begin
          if (cnt == CNT_MAX) sticky_d = 1'b1;
          else                cnt_d    = cnt + CNT_W'(1);
        end
        if (timer == GATE_LAST) begin
          state_d       = ST_PUBLISH;
          timer_d       = '0;
          count_d       = cnt_d;
          overflow_d    = sticky_d;
          count_ch_d    = ch;
          count_valid_d = 1'b1;
          frame_done_d  = (ch == LAST_CH);
        end else begin
          timer_d = timer + TMR_W'(1);
        end
      end
      ST_PUBLISH: begin
        if (enable) begin
          state_d = ST_SETTLE;
          ch_d    = (ch == LAST_CH) ? 2'd0 : ch + 2'd1;
        end else begin
          state_d = ST_IDLE;
          ch_d    = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Filter code tracks the channel that will be active next cycle
    busy_d = (state_d != ST_IDLE);
    s2_d   = (ch_d == 2'd1) || (ch_d == 2'd3);
    s3_d   = (ch_d == 2'd1) || (ch_d == 2'd2);
  end

endmodule
